// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the pipelined floating-point adder: default field
// widths, bias / exponent-limit helpers and packed field structs.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package fp_pkg;

  localparam int EXP_W_DEF   = 6;
  localparam int MAN_W_DEF   = 12;
  localparam int GUARD_W_DEF = 2;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int fp_exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  // Operand / result fields at the default widths.
  typedef struct packed {
    logic                 sign;
    logic [EXP_W_DEF-1:0] exp;
    logic [MAN_W_DEF-1:0] man;
  } fp_t;

  typedef struct packed {
    logic                 sign;
    logic [EXP_W_DEF-1:0] exp;
    logic [MAN_W_DEF-1:0] man;
    logic                 ovf;
    logic                 unf;
  } fp_res_t;

endpackage

// File: rtl/fp_adder_pipe_if.sv
// -----------------------------------------------------------------------------
// fp_adder_pipe_if
// Operand/result bus for fp_adder_pipe with valid/ready handshakes on both
// sides.
//   master : producer of operands and consumer of results (testbench/neuron)
//   slave  : the adder itself
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface fp_adder_pipe_if
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
);
  logic             InValid;
  logic             InReady;
  logic             Sub;
  logic             SignA;
  logic [EXP_W-1:0] ExponentA;
  logic [MAN_W-1:0] MantissaA;
  logic             SignB;
  logic [EXP_W-1:0] ExponentB;
  logic [MAN_W-1:0] MantissaB;
  logic             OutValid;
  logic             OutReady;
  logic             SignOut;
  logic [EXP_W-1:0] ExponentOut;
  logic [MAN_W-1:0] MantissaOut;
  logic             Overflow;
  logic             Underflow;

  modport master (
    output InValid, Sub, SignA, ExponentA, MantissaA,
           SignB, ExponentB, MantissaB, OutReady,
    input  InReady, OutValid, SignOut, ExponentOut, MantissaOut,
           Overflow, Underflow
  );

  modport slave (
    input  InValid, Sub, SignA, ExponentA, MantissaA,
           SignB, ExponentB, MantissaB, OutReady,
    output InReady, OutValid, SignOut, ExponentOut, MantissaOut,
           Overflow, Underflow
  );

endinterface

// File: rtl/fp_lzc.sv
// -----------------------------------------------------------------------------
// fp_lzc
// Combinational leading-zero counter.
//   i_data  : vector to scan, MSB first
//   o_count : number of zeros above the most significant 1 (WIDTH if all 0)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module fp_lzc #(
  parameter int WIDTH = 15,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  output logic [CNT_W-1:0] o_count
);

  // Scan upward so the highest set bit is the last one to write the count.
  always_comb begin
    o_count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_data[i]) o_count = CNT_W'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_adder_pipe.sv
// -----------------------------------------------------------------------------
// fp_adder_pipe
// Three-stage pipelined floating-point adder/subtractor (truncating).
//   Clock  : rising-edge clock
//   ResetN : asynchronous active-low reset
//   bus    : fp_adder_pipe_if.slave - operands A/B + Sub in with InValid /
//            InReady, result + Overflow/Underflow out with OutValid / OutReady
// Stages: S1 align (registers r1_*), S2 add/sub (r2_*), S3 normalise into the
// output registers. The whole pipe freezes while a result waits downstream.
// GUARD_W must be at least 1.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module fp_adder_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W   = EXP_W_DEF,
  parameter int MAN_W   = MAN_W_DEF,
  parameter int GUARD_W = GUARD_W_DEF
) (
  input  logic          Clock,
  input  logic          ResetN,
  fp_adder_pipe_if.slave bus
);

  localparam int SIG_W = MAN_W + 1 + GUARD_W;
  localparam int CNT_W = $clog2(SIG_W + 1);
  localparam int XE_W  = EXP_W + 2;
  localparam logic signed [XE_W-1:0] EXP_MAX  = XE_W'(fp_exp_max(EXP_W));
  localparam logic signed [XE_W-1:0] EXP_ZERO = '0;

  logic w_advance;

  // ---------------- S1: align ----------------
  logic             w_sign_b;
  logic             w_a_ge;
  logic [SIG_W-1:0] w_sig_a, w_sig_b;
  logic             w_sign_l, w_sign_s;
  logic [EXP_W-1:0] w_exp_l, w_exp_s, w_shift;
  logic [SIG_W-1:0] w_sig_l, w_sig_s, w_sig_s_al;

  logic             r1_valid, r1_sign_l, r1_sign_s;
  logic [EXP_W-1:0] r1_exp;
  logic [SIG_W-1:0] r1_sig_l, r1_sig_s;

  assign w_sign_b = bus.SignB ^ bus.Sub;
  assign w_a_ge   = {bus.ExponentA, bus.MantissaA} >= {bus.ExponentB, bus.MantissaB};
  assign w_sig_a  = (bus.ExponentA != '0) ? {1'b1, bus.MantissaA, {GUARD_W{1'b0}}} : '0;
  assign w_sig_b  = (bus.ExponentB != '0) ? {1'b1, bus.MantissaB, {GUARD_W{1'b0}}} : '0;

  always_comb begin
    if (w_a_ge) begin
      w_sign_l = bus.SignA;  w_exp_l = bus.ExponentA; w_sig_l = w_sig_a;
      w_sign_s = w_sign_b;   w_exp_s = bus.ExponentB; w_sig_s = w_sig_b;
    end else begin
      w_sign_l = w_sign_b;   w_exp_l = bus.ExponentB; w_sig_l = w_sig_b;
      w_sign_s = bus.SignA;  w_exp_s = bus.ExponentA; w_sig_s = w_sig_a;
    end
  end

  assign w_shift    = w_exp_l - w_exp_s;
  assign w_sig_s_al = (int'(w_shift) >= SIG_W) ? '0 : (w_sig_s >> w_shift);

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r1_valid  <= 1'b0;
      r1_sign_l <= 1'b0;
      r1_sign_s <= 1'b0;
      r1_exp    <= '0;
      r1_sig_l  <= '0;
      r1_sig_s  <= '0;
    end else if (w_advance) begin
      r1_valid  <= bus.InValid;
      r1_sign_l <= w_sign_l;
      r1_sign_s <= w_sign_s;
      r1_exp    <= w_exp_l;
      r1_sig_l  <= w_sig_l;
      r1_sig_s  <= w_sig_s_al;
    end
  end

  // ---------------- S2: add / subtract ----------------
  // Larger-magnitude operand is always r1_sig_l, so subtraction never wraps.
  logic [SIG_W:0]   w_sum;
  logic             r2_valid, r2_sign;
  logic [EXP_W-1:0] r2_exp;
  logic [SIG_W:0]   r2_sum;

  assign w_sum = (r1_sign_l == r1_sign_s) ? ({1'b0, r1_sig_l} + {1'b0, r1_sig_s})
                                          : ({1'b0, r1_sig_l} - {1'b0, r1_sig_s});

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r2_valid <= 1'b0;
      r2_sign  <= 1'b0;
      r2_exp   <= '0;
      r2_sum   <= '0;
    end else if (w_advance) begin
      r2_valid <= r1_valid;
      r2_sign  <= r1_sign_l;
      r2_exp   <= r1_exp;
      r2_sum   <= w_sum;
    end
  end

  // ---------------- S3: normalise ----------------
  logic                   w_carry;
  logic [CNT_W-1:0]       w_lzc;
  logic [SIG_W-1:0]       w_norm;
  logic signed [XE_W-1:0] w_exp_n;
  logic                   w_res_sign, w_ovf, w_unf;
  logic [EXP_W-1:0]       w_res_exp;
  logic [MAN_W-1:0]       w_res_man;
  logic                   w_unused;

  fp_lzc #(.WIDTH(SIG_W), .CNT_W(CNT_W)) u_lzc (
    .i_data  (r2_sum[SIG_W-1:0]),
    .o_count (w_lzc)
  );

  assign w_carry  = r2_sum[SIG_W];
  assign w_norm   = r2_sum[SIG_W-1:0] << w_lzc;
  // Hidden bit of the normalised value and the guard bits are dropped.
  assign w_unused = ^{w_norm[SIG_W-1], w_norm[GUARD_W-1:0]};

  always_comb begin
    if (w_carry) w_exp_n = $signed({2'b00, r2_exp}) + XE_W'(1);
    else         w_exp_n = $signed({2'b00, r2_exp}) - $signed(XE_W'(w_lzc));
  end

  always_comb begin
    w_res_sign = r2_sign;
    w_res_exp  = w_exp_n[EXP_W-1:0];
    w_res_man  = w_carry ? r2_sum[SIG_W-1:GUARD_W+1] : w_norm[SIG_W-2:GUARD_W];
    w_ovf      = 1'b0;
    w_unf      = 1'b0;
    if (r2_sum == '0) begin
      w_res_sign = 1'b0;
      w_res_exp  = '0;
      w_res_man  = '0;
    end else if (w_exp_n > EXP_MAX) begin
      w_res_exp  = '1;
      w_res_man  = '1;
      w_ovf      = 1'b1;
    end else if (w_exp_n <= EXP_ZERO) begin
      w_res_sign = 1'b0;
      w_res_exp  = '0;
      w_res_man  = '0;
      w_unf      = 1'b1;
    end
  end

  logic             r_out_valid, r_out_sign, r_out_ovf, r_out_unf;
  logic [EXP_W-1:0] r_out_exp;
  logic [MAN_W-1:0] r_out_man;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_out_valid <= 1'b0;
      r_out_sign  <= 1'b0;
      r_out_exp   <= '0;
      r_out_man   <= '0;
      r_out_ovf   <= 1'b0;
      r_out_unf   <= 1'b0;
    end else if (w_advance) begin
      r_out_valid <= r2_valid;
      r_out_sign  <= w_res_sign;
      r_out_exp   <= w_res_exp;
      r_out_man   <= w_res_man;
      r_out_ovf   <= w_ovf;
      r_out_unf   <= w_unf;
    end
  end

  // Freeze every stage while the output holds an unaccepted result.
  assign w_advance       = !(r_out_valid && !bus.OutReady);
  assign bus.InReady     = w_advance;
  assign bus.OutValid    = r_out_valid;
  assign bus.SignOut     = r_out_sign;
  assign bus.ExponentOut = r_out_exp;
  assign bus.MantissaOut = r_out_man;
  assign bus.Overflow    = r_out_ovf;
  assign bus.Underflow   = r_out_unf;

endmodule

// File: tb/tb_fp_adder_pipe.sv
`timescale 1ns/1ps
module tb_fp_adder_pipe;
  import fp_pkg::*;

  localparam int EXP_W   = EXP_W_DEF;
  localparam int MAN_W   = MAN_W_DEF;
  localparam int GUARD_W = GUARD_W_DEF;
  localparam int EMAX    = (1 << EXP_W) - 1;

  typedef struct packed {
    logic sub;
    fp_t  a;
    fp_t  b;
  } op_t;

  logic Clock  = 1'b0;
  logic ResetN = 1'b0;
  int   checks = 0;
  int   errors = 0;
  fp_res_t exp_q[$];

  always #5 Clock = ~Clock;

  fp_adder_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

  fp_adder_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .GUARD_W(GUARD_W)) dut (
    .Clock  (Clock),
    .ResetN (ResetN),
    .bus    (bus.slave)
  );

  // Reference: exact value arithmetic on integer significands scaled to the
  // larger operand's exponent, then renormalised from the magnitude's MSB.
  function automatic fp_res_t ref_add(input op_t op);
    fp_res_t r;
    longint  va, vb, vl, vs, mag;
    int      el, es, p, e;
    logic    sl, ss, sbe;
    r   = '0;
    sbe = op.b.sign ^ op.sub;
    va  = (op.a.exp == 0) ? 64'd0 : (longint'((1 << MAN_W) | op.a.man) << GUARD_W);
    vb  = (op.b.exp == 0) ? 64'd0 : (longint'((1 << MAN_W) | op.b.man) << GUARD_W);
    if ({op.a.exp, op.a.man} >= {op.b.exp, op.b.man}) begin
      vl = va; el = int'(op.a.exp); sl = op.a.sign;
      vs = vb; es = int'(op.b.exp); ss = sbe;
    end else begin
      vl = vb; el = int'(op.b.exp); sl = sbe;
      vs = va; es = int'(op.a.exp); ss = op.a.sign;
    end
    vs  = vs >> (el - es);
    mag = (sl == ss) ? vl + vs : vl - vs;
    if (mag == 0) return r;
    p = 0;
    for (int i = 0; i < 62; i++) if (mag[i]) p = i;
    e = el + p - (MAN_W + GUARD_W);
    if (e > EMAX) begin
      r.sign = sl; r.exp = '1; r.man = '1; r.ovf = 1'b1;
      return r;
    end
    if (e <= 0) begin
      r.unf = 1'b1;
      return r;
    end
    r.sign = sl;
    r.exp  = e[EXP_W-1:0];
    r.man  = (p >= MAN_W) ? MAN_W'(mag >> (p - MAN_W)) : MAN_W'(mag << (MAN_W - p));
    return r;
  endfunction

  function automatic op_t rand_op();
    op_t op;
    int  d;
    op.sub    = 1'($urandom);
    op.a.sign = 1'($urandom);
    op.a.exp  = ($urandom_range(0, 4) == 0) ? EXP_W'($urandom_range(EMAX - 1, EMAX))
                                            : EXP_W'($urandom_range(0, EMAX));
    op.a.man  = MAN_W'($urandom);
    op.b.sign = 1'($urandom);
    op.b.man  = MAN_W'($urandom);
    case ($urandom_range(0, 3))
      0: op.b.exp = EXP_W'($urandom_range(0, EMAX));
      1: begin
        d = int'(op.a.exp) + int'($urandom_range(0, 20)) - 10;
        if (d < 0) d = 0;
        if (d > EMAX) d = EMAX;
        op.b.exp = EXP_W'(d);
      end
      2: begin op.b.exp = op.a.exp; op.b.man = op.a.man; end
      default: op.b.exp = op.a.exp;
    endcase
    return op;
  endfunction

  function automatic fp_res_t dut_out();
    return fp_res_t'({bus.SignOut, bus.ExponentOut, bus.MantissaOut, bus.Overflow, bus.Underflow});
  endfunction

  // One cycle: drive at the falling edge, then observe 1ns later.
  task automatic step(input logic v, input op_t op, input logic ordy,
                      output logic in_x, output logic out_x);
    @(negedge Clock);
    bus.InValid   = v;
    bus.Sub       = op.sub;
    bus.SignA     = op.a.sign;
    bus.ExponentA = op.a.exp;
    bus.MantissaA = op.a.man;
    bus.SignB     = op.b.sign;
    bus.ExponentB = op.b.exp;
    bus.MantissaB = op.b.man;
    bus.OutReady  = ordy;
    #1;
    in_x  = v && bus.InReady;
    out_x = bus.OutValid && ordy;
  endtask

  task automatic test_reset();
    logic ix, ox;
    bus.InValid = 1'b0; bus.OutReady = 1'b1; bus.Sub = 1'b0;
    bus.SignA = 1'b0; bus.ExponentA = '0; bus.MantissaA = '0;
    bus.SignB = 1'b0; bus.ExponentB = '0; bus.MantissaB = '0;
    ResetN = 1'b0;
    repeat (3) @(negedge Clock);
    checks++;
    if (bus.OutValid !== 1'b0) begin
      errors++; $display("FAIL reset_outvalid: got %b want 0", bus.OutValid);
    end
    checks++;
    if (dut_out() !== fp_res_t'('0)) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", dut_out());
    end
    ResetN = 1'b1;
    step(1'b0, op_t'('0), 1'b1, ix, ox);
    checks++;
    if (bus.InReady !== 1'b1) begin
      errors++; $display("FAIL reset_inready: got %b want 1", bus.InReady);
    end
    checks++;
    if (bus.OutValid !== 1'b0) begin
      errors++; $display("FAIL reset_release_outvalid: got %b want 0", bus.OutValid);
    end
  endtask

  task automatic test_directed();
    op_t     ops[5];
    fp_res_t want[5];
    logic    ix, ox;
    int      lat;
    ops[0] = '{sub: 1'b0, a: '{1'b0, 6'd31, 12'h000}, b: '{1'b0, 6'd31, 12'h000}};
    want[0] = '{sign: 1'b0, exp: 6'd32, man: 12'h000, ovf: 1'b0, unf: 1'b0};
    ops[1] = '{sub: 1'b0, a: '{1'b1, 6'd4, 12'h04C}, b: '{1'b0, 6'd4, 12'h163}};
    want[1] = '{sign: 1'b0, exp: 6'd0, man: 12'h000, ovf: 1'b0, unf: 1'b1};
    ops[2] = '{sub: 1'b0, a: '{1'b0, 6'd63, 12'h800}, b: '{1'b0, 6'd63, 12'h800}};
    want[2] = '{sign: 1'b0, exp: 6'd63, man: 12'hFFF, ovf: 1'b1, unf: 1'b0};
    ops[3] = '{sub: 1'b1, a: '{1'b0, 6'd31, 12'h800}, b: '{1'b0, 6'd31, 12'h800}};
    want[3] = '{sign: 1'b0, exp: 6'd0, man: 12'h000, ovf: 1'b0, unf: 1'b0};
    ops[4] = '{sub: 1'b0, a: '{1'b0, 6'd31, 12'h000}, b: '{1'b0, 6'd10, 12'h123}};
    want[4] = '{sign: 1'b0, exp: 6'd31, man: 12'h000, ovf: 1'b0, unf: 1'b0};
    for (int c = 0; c < 5; c++) begin
      step(1'b1, ops[c], 1'b1, ix, ox);
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
        step(1'b0, ops[c], 1'b1, ix, ox);
        if (bus.OutValid === 1'b1) begin
          lat = k;
          break;
        end
      end
      checks++;
      if (lat != 3) begin
        errors++; $display("FAIL directed%0d_latency: got %0d want 3", c + 1, lat);
      end
      checks++;
      if (dut_out() !== want[c]) begin
        errors++; $display("FAIL directed%0d_result: got %h want %h", c + 1, dut_out(), want[c]);
      end
    end
  endtask

  task automatic test_random();
    op_t     op;
    logic    v, ordy, ix, ox, prev_stall;
    fp_res_t prev_out, got, want;
    int      idx, cyc;
    idx = 0; cyc = 0; prev_stall = 1'b0; prev_out = '0;
    exp_q.delete();
    op = rand_op();
    while ((idx < 300 || exp_q.size() != 0) && cyc < 4000) begin
      v    = (idx < 300) && ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      step(v, op, ordy, ix, ox);
      cyc++;
      got = dut_out();
      if (prev_stall) begin
        checks++;
        if (bus.OutValid !== 1'b1 || got !== prev_out) begin
          errors++; $display("FAIL rand_hold: got v=%b %h want v=1 %h", bus.OutValid, got, prev_out);
        end
      end
      checks++;
      if (bus.InReady !== !(bus.OutValid && ordy == 1'b0)) begin
        errors++; $display("FAIL rand_inready: got %b want %b", bus.InReady, !(bus.OutValid && !ordy));
      end
      if (ox) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_extra_result: got %h want none", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++; $display("FAIL rand_result: got %h want %h", got, want);
          end
        end
      end
      if (ix) begin
        exp_q.push_back(ref_add(op));
        idx++;
        op = rand_op();
      end
      prev_stall = bus.OutValid && !ordy;
      prev_out   = got;
    end
    checks++;
    if (idx != 300 || exp_q.size() != 0) begin
      errors++; $display("FAIL rand_timeout: got %0d sent %0d pending want 300 sent 0 pending", idx, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    op_t     ops[8];
    logic    ordy, ix, ox, prev_stall;
    fp_res_t prev_out, got, want;
    int      idx, cyc, nrx, extra;
    for (int i = 0; i < 8; i++) ops[i] = rand_op();
    idx = 0; cyc = 0; nrx = 0; prev_stall = 1'b0; prev_out = '0;
    exp_q.delete();
    while ((idx < 8 || exp_q.size() != 0) && cyc < 60) begin
      ordy = !(cyc >= 4 && cyc <= 6);
      step(idx < 8, ops[idx % 8], ordy, ix, ox);
      got = dut_out();
      if (bus.OutValid && !ordy) begin
        checks++;
        if (bus.InReady !== 1'b0) begin
          errors++; $display("FAIL b2b_inready_stall: cycle %0d got %b want 0", cyc, bus.InReady);
        end
      end
      if (prev_stall) begin
        checks++;
        if (bus.OutValid !== 1'b1 || got !== prev_out) begin
          errors++; $display("FAIL b2b_hold: got %h want %h", got, prev_out);
        end
      end
      if (ox) begin
        nrx++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra: got %h want none", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++; $display("FAIL b2b_result%0d: got %h want %h", nrx, got, want);
          end
        end
      end
      if (ix) begin
        exp_q.push_back(ref_add(ops[idx]));
        idx++;
      end
      prev_stall = bus.OutValid && !ordy;
      prev_out   = got;
      cyc++;
    end
    extra = 0;
    repeat (5) begin
      step(1'b0, ops[0], 1'b1, ix, ox);
      if (ox) extra++;
    end
    checks++;
    if (nrx != 8 || extra != 0) begin
      errors++; $display("FAIL b2b_count: got %0d+%0d results want 8+0", nrx, extra);
    end
  endtask

  task automatic test_reset_mid();
    op_t     op;
    logic    ix, ox;
    int      spurious, cyc;
    fp_res_t want;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      op = rand_op();
      step(1'b1, op, 1'b1, ix, ox);
    end
    #2 ResetN = 1'b0;
    #1;
    checks++;
    if (bus.OutValid !== 1'b0) begin
      errors++; $display("FAIL midreset_outvalid: got %b want 0", bus.OutValid);
    end
    checks++;
    if (bus.InReady !== 1'b1) begin
      errors++; $display("FAIL midreset_inready: got %b want 1", bus.InReady);
    end
    step(1'b0, op, 1'b1, ix, ox);
    ResetN = 1'b1;
    spurious = 0;
    repeat (6) begin
      step(1'b0, op, 1'b1, ix, ox);
      if (bus.OutValid !== 1'b0) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      errors++; $display("FAIL midreset_no_valid: got %0d valid cycles want 0", spurious);
    end
    op = rand_op();
    want = ref_add(op);
    step(1'b1, op, 1'b1, ix, ox);
    cyc = 0;
    do begin
      step(1'b0, op, 1'b1, ix, ox);
      cyc++;
    end while (!ox && cyc < 10);
    checks++;
    if (!ox || dut_out() !== want) begin
      errors++; $display("FAIL midreset_after: got v=%b %h want v=1 %h", ox, dut_out(), want);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
